// File: rtl/irq_ctx_ctrl.sv
// Interrupt context controller: saves PC/flags into r12/r13 through the shared write port
// and restores them on IRET. Optional macro IRQ_EDGE_EN selects edge-triggered requests.
module irq_ctx_ctrl #(
    parameter logic [31:0] VEC_ADDR = 32'd0,
    parameter logic [3:0]  PC_REG   = 4'd12,
    parameter logic [3:0]  FLAG_REG = 4'd13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irq_req,
    input  logic        iret,
    input  logic [31:0] pc_ex,
    input  logic [1:0]  flags_in,
    input  logic        wb_en,
    input  logic [3:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic [31:0] rf_rdata,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        rf_rsel,
    output logic [3:0]  rf_raddr,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [1:0]  flags_out,
    output logic        flags_valid,
    output logic        irq_ack,
    output logic        in_isr,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE, SAVE_PC, SAVE_FLAGS, VECTOR, IN_ISR, RESTORE_FLAGS, RESTORE_PC
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] saved_pc;
    logic [1:0]  saved_flags;
    logic        take_irq;
    logic        ctl_we;
    logic [3:0]  ctl_waddr;
    logic [31:0] ctl_wdata;
    logic [31:0] pc_rd_val;
    logic [1:0]  flag_rd_val;

    assign state_dbg = state;

`ifdef IRQ_EDGE_EN
    logic irq_q, irq_pend, irq_edge;
    assign irq_edge = irq_req & ~irq_q;
    assign take_irq = (state == IDLE) & (irq_edge | irq_pend);

    // One-deep pending latch for edges seen while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q    <= 1'b0;
            irq_pend <= 1'b0;
        end else begin
            irq_q <= irq_req;
            if (take_irq)
                irq_pend <= 1'b0;
            else if (irq_edge && state != IDLE)
                irq_pend <= 1'b1;
        end
    end
`else
    assign take_irq = (state == IDLE) & irq_req;
`endif

    // A same-cycle writeback to the register being restored is newer than the RF copy.
    assign pc_rd_val   = (wb_en && wb_rd == PC_REG)   ? wb_data      : rf_rdata;
    assign flag_rd_val = (wb_en && wb_rd == FLAG_REG) ? wb_data[1:0] : rf_rdata[1:0];

    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        irq_ack     = 1'b0;
        in_isr      = 1'b0;
        rf_rsel     = 1'b0;
        rf_raddr    = 4'd0;
        ctl_we      = 1'b0;
        ctl_waddr   = 4'd0;
        ctl_wdata   = 32'd0;
        case (state)
            IDLE: begin
                if (take_irq) begin
                    irq_ack   = 1'b1;
                    state_nxt = SAVE_PC;
                end
            end
            SAVE_PC: begin
                stall = 1'b1;
                if (!wb_en) begin
                    ctl_we    = 1'b1;
                    ctl_waddr = PC_REG;
                    ctl_wdata = saved_pc;
                    state_nxt = SAVE_FLAGS;
                end
            end
            SAVE_FLAGS: begin
                stall = 1'b1;
                if (!wb_en) begin
                    ctl_we    = 1'b1;
                    ctl_waddr = FLAG_REG;
                    ctl_wdata = {30'b0, saved_flags};
                    state_nxt = VECTOR;
                end
            end
            VECTOR: begin
                stall       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = VEC_ADDR;
                state_nxt   = IN_ISR;
            end
            IN_ISR: begin
                in_isr = 1'b1;
                if (iret)
                    state_nxt = RESTORE_FLAGS;
            end
            RESTORE_FLAGS: begin
                stall     = 1'b1;
                rf_rsel   = 1'b1;
                rf_raddr  = FLAG_REG;
                state_nxt = RESTORE_PC;
            end
            RESTORE_PC: begin
                stall       = 1'b1;
                rf_rsel     = 1'b1;
                rf_raddr    = PC_REG;
                redirect    = 1'b1;
                redirect_pc = pc_rd_val;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Reset aborts any sequence: no controller write or redirect in that cycle.
        if (rst) begin
            state_nxt   = IDLE;
            stall       = 1'b0;
            redirect    = 1'b0;
            redirect_pc = 32'd0;
            irq_ack     = 1'b0;
            in_isr      = 1'b0;
            rf_rsel     = 1'b0;
            rf_raddr    = 4'd0;
            ctl_we      = 1'b0;
            ctl_waddr   = 4'd0;
            ctl_wdata   = 32'd0;
        end
    end

    // Pipeline writeback always owns the port when it wants it.
    always_comb begin
        rf_we    = wb_en | ctl_we;
        rf_waddr = wb_en ? wb_rd   : ctl_waddr;
        rf_wdata = wb_en ? wb_data : ctl_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            saved_pc    <= 32'd0;
            saved_flags <= 2'd0;
            flags_out   <= 2'd0;
            flags_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            flags_valid <= 1'b0;
            if (take_irq) begin
                saved_pc    <= pc_ex;
                saved_flags <= flags_in;
            end
            if (state == RESTORE_FLAGS) begin
                flags_out   <= flag_rd_val;
                flags_valid <= 1'b1;
            end
        end
    end

endmodule
